// File: rtl/fpu_fpr_wb_if.sv
// fpu_fpr_wb_if -- bundle of all non-clock signals between the FP writeback
// stage and its neighbours (load unit, FPU, issue stage, FP register file).
//   load return   : ld_valid, ld_rd, ld_data (no backpressure)
//   FPU result    : fpu_res_valid/fpu_res_ready handshake, fpu_res_rd, fpu_res_data
//   issue check   : issue_valid, issue_rd, rs0..rs2, rs0_en..rs2_en -> hz0..hz2, hz_rd, busy
//   regfile write : wen0, waddr0, wd0
//   forwarding    : fwd0..fwd2, fwd_data0..fwd_data2 (only with FPU_FPR_WB_BYPASS_EN)
// modport slave is the writeback stage, modport master is its environment.
interface fpu_fpr_wb_if #(parameter int FPLEN = 16);
  logic             ld_valid;
  logic [4:0]       ld_rd;
  logic [FPLEN-1:0] ld_data;
  logic             fpu_res_valid;
  logic             fpu_res_ready;
  logic [4:0]       fpu_res_rd;
  logic [FPLEN-1:0] fpu_res_data;
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic [4:0]       rs0, rs1, rs2;
  logic             rs0_en, rs1_en, rs2_en;
  logic             hz0, hz1, hz2;
  logic             hz_rd;
  logic [31:0]      busy;
  logic             wen0;
  logic [4:0]       waddr0;
  logic [FPLEN-1:0] wd0;
`ifdef FPU_FPR_WB_BYPASS_EN
  logic             fwd0, fwd1, fwd2;
  logic [FPLEN-1:0] fwd_data0, fwd_data1, fwd_data2;
`endif

  modport slave (
    input  ld_valid, ld_rd, ld_data,
    input  fpu_res_valid, fpu_res_rd, fpu_res_data,
    output fpu_res_ready,
    input  issue_valid, issue_rd, rs0, rs1, rs2, rs0_en, rs1_en, rs2_en,
    output hz0, hz1, hz2, hz_rd, busy,
    output wen0, waddr0, wd0
`ifdef FPU_FPR_WB_BYPASS_EN
   ,output fwd0, fwd1, fwd2, fwd_data0, fwd_data1, fwd_data2
`endif
  );

  modport master (
    output ld_valid, ld_rd, ld_data,
    output fpu_res_valid, fpu_res_rd, fpu_res_data,
    input  fpu_res_ready,
    output issue_valid, issue_rd, rs0, rs1, rs2, rs0_en, rs1_en, rs2_en,
    input  hz0, hz1, hz2, hz_rd, busy,
    input  wen0, waddr0, wd0
`ifdef FPU_FPR_WB_BYPASS_EN
   ,input  fwd0, fwd1, fwd2, fwd_data0, fwd_data1, fwd_data2
`endif
  );
endinterface

// File: rtl/fpu_fpr_wb.sv
// fpu_fpr_wb -- FP register-file writeback stage.
// Merges FP load returns (highest priority, never stalled) and FPU results
// (valid/ready, buffered in a DEPTH-entry FIFO) into one registered write per
// cycle on the register file port wen0/waddr0/wd0. Keeps a 32-entry
// pending-write scoreboard and produces RAW/WAW hazard flags for issue.
// Ports:
//   clk   - clock
//   rst_l - synchronous active-low reset
//   bus   - fpu_fpr_wb_if.slave (load, FPU, issue-check and regfile signals)
// Parameters: FPLEN (data width), DEPTH (FPU result FIFO entries, >=1).
// Optional: define FPU_FPR_WB_BYPASS_EN to add write-to-read forwarding
// outputs fwd0..2/fwd_data0..2; a forwarded source no longer flags a hazard.
module fpu_fpr_wb #(
  parameter int FPLEN = 16,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          rst_l,
  fpu_fpr_wb_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]       rd;
    logic [FPLEN-1:0] data;
  } wb_req_t;

  wb_req_t          mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wen0_q, wen0_d;
  logic [4:0]       waddr0_q, waddr0_d;
  logic [FPLEN-1:0] wd0_q, wd0_d;
  logic [31:0]      busy_q, busy_d;
  logic             ready, accept, empty, push, pop;
  wb_req_t          head, fpu_req;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered state so the producer sees no comb path
  // through its own valid.
  assign ready   = (count_q < CW'(DEPTH));
  assign accept  = bus.fpu_res_valid & ready;
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign fpu_req = '{rd: bus.fpu_res_rd, data: bus.fpu_res_data};

  always_comb begin
    wen0_d   = 1'b0;
    waddr0_d = waddr0_q;
    wd0_d    = wd0_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (bus.ld_valid) begin
      wen0_d   = 1'b1;
      waddr0_d = bus.ld_rd;
      wd0_d    = bus.ld_data;
      push     = accept;
    end else if (!empty) begin
      wen0_d   = 1'b1;
      waddr0_d = head.rd;
      wd0_d    = head.data;
      pop      = 1'b1;
      push     = accept;
    end else if (accept) begin
      // Empty FIFO: the FPU result goes straight to the output register.
      wen0_d   = 1'b1;
      waddr0_d = fpu_req.rd;
      wd0_d    = fpu_req.data;
    end

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so a same-edge set on the same register wins.
    busy_d = busy_q;
    if (wen0_q)          busy_d[waddr0_q]     = 1'b0;
    if (bus.issue_valid) busy_d[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wen0_q   <= 1'b0;
      waddr0_q <= '0;
      wd0_q    <= '0;
      busy_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wen0_q   <= wen0_d;
      waddr0_q <= waddr0_d;
      wd0_q    <= wd0_d;
      busy_q   <= busy_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (rst_l && push) mem_q[wr_ptr_q] <= fpu_req;
  end

  // Per-source hazard check.
  logic [2:0][4:0] rs;
  logic [2:0]      rs_en, hz;
  assign rs    = {bus.rs2, bus.rs1, bus.rs0};
  assign rs_en = {bus.rs2_en, bus.rs1_en, bus.rs0_en};

`ifdef FPU_FPR_WB_BYPASS_EN
  logic [2:0] fwd;
  for (genvar k = 0; k < 3; k++) begin : g_src
    assign fwd[k] = wen0_q & rs_en[k] & (waddr0_q == rs[k]);
    assign hz[k]  = rs_en[k] & busy_q[rs[k]] & ~fwd[k];
  end
  assign bus.fwd0      = fwd[0];
  assign bus.fwd1      = fwd[1];
  assign bus.fwd2      = fwd[2];
  assign bus.fwd_data0 = wd0_q;
  assign bus.fwd_data1 = wd0_q;
  assign bus.fwd_data2 = wd0_q;
`else
  for (genvar k = 0; k < 3; k++) begin : g_src
    assign hz[k] = rs_en[k] & busy_q[rs[k]];
  end
`endif

  assign bus.hz0           = hz[0];
  assign bus.hz1           = hz[1];
  assign bus.hz2           = hz[2];
  assign bus.hz_rd         = bus.issue_valid & busy_q[bus.issue_rd];
  assign bus.busy          = busy_q;
  assign bus.fpu_res_ready = ready;
  assign bus.wen0          = wen0_q;
  assign bus.waddr0        = waddr0_q;
  assign bus.wd0           = wd0_q;

endmodule

// File: tb/tb_fpu_fpr_wb.sv
module tb_fpu_fpr_wb;
  logic clk;
  logic rst_l;
  int   checks   = 0;
  int   failures = 0;

  fpu_fpr_wb_if #(.FPLEN(16)) bus ();
  fpu_fpr_wb #(.FPLEN(16), .DEPTH(2)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] en, input logic [31:0] rd,
                        input logic [31:0] data);
    chk({tag, "_wen"},   32'(bus.wen0),   en);
    chk({tag, "_waddr"}, 32'(bus.waddr0), rd);
    chk({tag, "_wd"},    32'(bus.wd0),    data);
  endtask

  int exp_rdy [6] = '{1, 1, 0, 0, 0, 1};
  int exp_rd  [7] = '{20, 21, 22, 23, 24, 25, 26};

  initial begin
    int idx;
    rst_l = 1'b0;
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    bus.fpu_res_valid = 1'b0; bus.fpu_res_rd = '0; bus.fpu_res_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs0 = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.rs0_en = 1'b0; bus.rs1_en = 1'b0; bus.rs2_en = 1'b0;
    step(); step();
    rst_l = 1'b1;
    step();
    chk_wr("init", 32'd0, 32'd0, 32'd0);
    chk("init_busy", bus.busy, 32'd0);
    chk("init_ready", 32'(bus.fpu_res_ready), 32'd1);

    // Reset mid-operation: busy=6 and two results parked in the FIFO.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd1; step();
    bus.issue_rd = 5'd2; step();
    bus.issue_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 16'h1111;
    bus.fpu_res_valid = 1'b1; bus.fpu_res_rd = 5'd11; bus.fpu_res_data = 16'h2222;
    step();
    bus.ld_rd = 5'd13; bus.ld_data = 16'h4444;
    bus.fpu_res_rd = 5'd12; bus.fpu_res_data = 16'h3333;
    step();
    chk("pre_rst_ready", 32'(bus.fpu_res_ready), 32'd0);
    chk("pre_rst_busy", bus.busy, 32'h6);
    bus.ld_valid = 1'b0; bus.fpu_res_valid = 1'b0;
    rst_l = 1'b0;
    step(); step();
    chk("rst_wen", 32'(bus.wen0), 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_ready", 32'(bus.fpu_res_ready), 32'd1);
    rst_l = 1'b1;
    step();
    chk("rst_drop0", 32'(bus.wen0), 32'd0);
    step();
    chk("rst_drop1", 32'(bus.wen0), 32'd0);

    // Load latency and RAW hazard on rs0.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd3; step();
    bus.issue_valid = 1'b0;
    chk("lat_busy", bus.busy, 32'h8);
    bus.rs0 = 5'd3; bus.rs0_en = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 16'h3C00;
    #1;
    chk("lat_hz_N", 32'(bus.hz0), 32'd1);
    step();
    bus.ld_valid = 1'b0;
    chk_wr("lat_N1", 32'd1, 32'd3, 32'h3C00);
    chk("lat_busy_N1", bus.busy, 32'h8);
`ifdef FPU_FPR_WB_BYPASS_EN
    chk("lat_hz_N1", 32'(bus.hz0), 32'd0);
    chk("lat_fwd_N1", 32'(bus.fwd0), 32'd1);
`else
    chk("lat_hz_N1", 32'(bus.hz0), 32'd1);
`endif
    step();
    chk("lat_wen_N2", 32'(bus.wen0), 32'd0);
    chk("lat_busy_N2", bus.busy, 32'd0);
    chk("lat_hz_N2", 32'(bus.hz0), 32'd0);
    bus.rs0_en = 1'b0;

    // Load beats FPU in the same cycle; FPU follows one cycle later.
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd1; bus.ld_data = 16'h4000;
    bus.fpu_res_valid = 1'b1; bus.fpu_res_rd = 5'd2; bus.fpu_res_data = 16'h4200;
    step();
    bus.ld_valid = 1'b0; bus.fpu_res_valid = 1'b0;
    chk_wr("prio_N1", 32'd1, 32'd1, 32'h4000);
    step();
    chk_wr("prio_N2", 32'd1, 32'd2, 32'h4200);
    step();
    chk_wr("prio_idle", 32'd0, 32'd2, 32'h4200);

    // FIFO empty: FPU result bypasses with latency 1.
    bus.fpu_res_valid = 1'b1; bus.fpu_res_rd = 5'd4; bus.fpu_res_data = 16'h1234;
    step();
    bus.fpu_res_valid = 1'b0;
    chk_wr("fpu_byp", 32'd1, 32'd4, 32'h1234);
    step();
    chk("fpu_byp_idle", 32'(bus.wen0), 32'd0);

    // FIFO full: 4 loads back to back, 3 FPU results offered.
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      bus.ld_valid = (i < 4);
      bus.ld_rd = 5'(20 + i); bus.ld_data = 16'(16'hA000 + 20 + i);
      bus.fpu_res_valid = (idx < 3);
      bus.fpu_res_rd = 5'(24 + idx); bus.fpu_res_data = 16'(16'hB000 + 24 + idx);
      #1;
      if (i < 6) chk($sformatf("full_ready%0d", i), 32'(bus.fpu_res_ready), 32'(exp_rdy[i]));
      step();
      if (i < 6 && idx < 3 && exp_rdy[i] == 1) idx++;
      chk_wr($sformatf("full_wr%0d", i), 32'd1, 32'(exp_rd[i]),
             (exp_rd[i] < 24) ? 32'(16'hA000 + exp_rd[i]) : 32'(16'hB000 + exp_rd[i]));
    end
    bus.ld_valid = 1'b0; bus.fpu_res_valid = 1'b0;
    step();
    chk("full_drained", 32'(bus.wen0), 32'd0);
    chk("full_ready_end", 32'(bus.fpu_res_ready), 32'd1);

    // Set/clear collision on register 5.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; step();
    bus.issue_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; bus.ld_data = 16'h5555;
    step();
    bus.ld_valid = 1'b0;
    chk_wr("coll_wr", 32'd1, 32'd5, 32'h5555);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
    #1;
    chk("coll_hzrd_a", 32'(bus.hz_rd), 32'd1);
    step();
    chk("coll_busy", bus.busy, 32'h20);
    chk("coll_hzrd_b", 32'(bus.hz_rd), 32'd1);
    bus.issue_valid = 1'b0;
    #1;
    chk("coll_hzrd_off", 32'(bus.hz_rd), 32'd0);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd5; step();
    bus.ld_valid = 1'b0; step();
    chk("coll_clear", bus.busy, 32'd0);

    // Write-cycle view of a pending register on rs1/rs2.
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; step();
    bus.issue_valid = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 16'hC500;
    step();
    bus.ld_valid = 1'b0;
    bus.rs1 = 5'd7; bus.rs1_en = 1'b1;
    bus.rs2 = 5'd7; bus.rs2_en = 1'b0;
    #1;
    chk_wr("byp_wr", 32'd1, 32'd7, 32'hC500);
    chk("byp_hz2_unused", 32'(bus.hz2), 32'd0);
`ifdef FPU_FPR_WB_BYPASS_EN
    chk("byp_fwd1", 32'(bus.fwd1), 32'd1);
    chk("byp_fwd_data1", 32'(bus.fwd_data1), 32'hC500);
    chk("byp_hz1", 32'(bus.hz1), 32'd0);
    chk("byp_fwd2_unused", 32'(bus.fwd2), 32'd0);
`else
    chk("byp_hz1", 32'(bus.hz1), 32'd1);
`endif
    step();
    chk("byp_hz1_after", 32'(bus.hz1), 32'd0);
    bus.rs1_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_fpr_wb.md
Name: fpu_fpr_wb

Overview:
- Writeback stage directly upstream of the FP register file; sole driver of its single write port (wen0/waddr0/wd0).
- Merges two result sources into one registered write per cycle:
  - FP load returns: no backpressure, highest priority.
  - FPU arithmetic results: valid/ready handshake, buffered in a small FIFO.
- Holds a 32-entry pending-write scoreboard; the issue stage uses its hazard outputs to stall RAW/WAW.

Parameters:
- FPLEN, 16, FP register/data width.
- DEPTH, 2, FPU result FIFO entries (>=1).

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset; synchronous, active-low.
- ld_valid  in  1  load result valid; always accepted.
- ld_rd  in  5  load destination register.
- ld_data  in  FPLEN  load data.
- fpu_res_valid  in  1  FPU result valid.
- fpu_res_ready  out  1  FIFO can accept.
- fpu_res_rd  in  5  FPU destination register.
- fpu_res_data  in  FPLEN  FPU result.
- issue_valid  in  1  instruction with FP destination issued this cycle.
- issue_rd  in  5  its destination register.
- rs0..rs2  in  5 each  source addresses being checked.
- rs0_en..rs2_en  in  1 each  source actually read.
- hz0..hz2  out  1 each  source hazard.
- hz_rd  out  1  issue_rd already pending (WAW).
- busy  out  32  scoreboard vector.
- wen0  out  1  register-file write enable.
- waddr0  out  5  register-file write address.
- wd0  out  FPLEN  register-file write data.

Behaviour:
- Reset (rst_l=0 at posedge):
  - wen0=0, waddr0=0, wd0=0, busy=0.
  - FIFO emptied, count=0.
  - In-flight results are dropped. Reset mid-operation discards all buffered data.
- Output register: wen0/waddr0/wd0 are flops. Exactly one write per cycle at most.
- Per-cycle selection for the next output register value, in priority order:
  1. ld_valid: write the load; latency 1 (ld_valid at cycle N -> wen0 at N+1).
  2. FIFO non-empty: pop the head and write it.
  3. FIFO empty and an FPU handshake this cycle: result bypasses the FIFO, latency 1.
  4. Otherwise wen0=0. waddr0/wd0 hold their previous values.
- FPU handshake and FIFO:
  - Accept when fpu_res_valid & fpu_res_ready.
  - fpu_res_ready = (count<DEPTH), combinational from registered count only.
  - An accepted result not taken by the bypass (load present, or FIFO non-empty) is pushed at the tail.
  - Push and pop in the same cycle: count unchanged.
  - Full: ready=0. valid held by the producer is not accepted.
  - Pointers wrap modulo DEPTH. FIFO order is preserved.
- Scoreboard:
  - busy[issue_rd] is set on the edge where issue_valid=1.
  - busy[waddr0] is cleared on the edge where wen0=1.
  - Same register set and cleared on the same edge: set wins.
  - All 32 registers are trackable (no hardwired zero register).
- Hazards (combinational):
  - hzK = rsK_en & busy[rsK].
  - hz_rd = issue_valid & busy[issue_rd].
  - The issue stage must not issue while any used hz is high. No ordering is guaranteed between load and FPU writes to the same register.
- Reads of the register file in the cycle after wen0 see the new data. Forwarding is only available under the optional feature.

Optional Feature:
- Macro: FPU_FPR_WB_BYPASS_EN.
- Defined: adds outputs fwd0..fwd2 (1 each) and fwd_data0..fwd_data2 (FPLEN each).
  - fwdK = wen0 & rsK_en & (waddr0==rsK); fwd_dataK = wd0.
  - hzK is suppressed when fwdK=1.
  - Consumer muxes fwd_dataK over the register-file read data.
- Undefined: no forwarding ports. hzK stays high until busy clears; the issue stage waits one extra cycle.

Test Plan:
- Reset: drive rst_l=0 for 2 cycles with FIFO holding 2 results and busy=0x0000_0006 -> afterwards wen0=0, busy=0, fpu_res_ready=1, no writes emitted.
- Load latency: issue_rd=3, then ld_valid ld_rd=3 ld_data=0x3C00 at cycle N -> wen0=1 waddr0=3 wd0=0x3C00 at N+1; busy[3]=0 from N+2; hz0 with rs0=3 high until N+1 inclusive.
- Priority:
  - Stimulus: same cycle ld_valid(rd=1, 0x4000) and FPU result (rd=2, 0x4200).
  - Response: load written at N+1, FPU written at N+2, count returns to 0.
- FIFO full:
  - Stimulus: ld_valid held 4 cycles while FPU presents 3 results (DEPTH=2).
  - Response: ready drops after 2 accepts; 3rd accepted only after a pop; FPU writes drain in order after the loads.
- Set/clear collision: wen0 for rd=5 on the same edge as issue_valid issue_rd=5 -> busy[5] stays 1; hz_rd=1 for a following issue to 5.
- Bypass (FPU_FPR_WB_BYPASS_EN defined): wen0=1 waddr0=7 wd0=0xC500 with rs1=7 rs1_en=1 -> fwd1=1, fwd_data1=0xC500, hz1=0. Undefined build -> hz1=1 that cycle.
